ks_data_path_param: RTL
=======================

Name: ks_data_path_param

Overview:
- Parametrised next-generation K&S data path: PC, IR, instruction decoder, NUM_REGS register file, 8-op ALU, flags register, and a new return-address stack for CALL/RET.
- Sits between the K&S control unit, which drives all enables and selects, and the single-port program/data RAM.
- Word width, register count, address width and stack depth are generic.

Parameters:
- DATA_W, 16, word/instruction width; must satisfy DATA_W >= 8+ADDR_W+RW and DATA_W >= 8+3*RW.
- NUM_REGS, 4, register count, power of two >= 2; RW = $clog2(NUM_REGS).
- ADDR_W, 5, RAM address and PC width.
- STACK_DEPTH, 4, return-address stack entries, >= 1.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- branch, input, 1, PC loads mem_addr when pc_enable.
- pc_enable, input, 1, PC update strobe.
- ir_enable, input, 1, IR loads data_in.
- addr_sel, input, 1, ram_addr select: 1 = PC, 0 = mem_addr.
- c_sel, input, 1, bus_c select: 1 = ALU result, 0 = data_in.
- operation, input, 3, ALU op.
- write_reg_enable, input, 1, register file write.
- flags_reg_enable, input, 1, flags register load.
- stack_push, input, 1, push return address; qualified by pc_enable.
- stack_pop, input, 1, pop into PC; qualified by pc_enable.
- decoded_instruction, output, decoded_instruction_type, decoded opcode.
- zero_op / neg_op / unsigned_overflow / signed_overflow, output, 1 each, registered flags.
- stack_empty / stack_full, output, 1 each, stack status, combinational from occupancy.
- stack_err, output, 1, sticky stack misuse flag.
- ram_addr, output, ADDR_W, RAM address.
- data_out, output, DATA_W, equals bus_a.
- data_in, input, DATA_W, RAM read data.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - PC, IR, all registers and all flags = 0.
  - Stack empty, stack_err = 0.
  - IR = 0 decodes as I_NOP.
- IR: loads data_in on clk when ir_enable=1, otherwise holds.
- PC update, only when pc_enable=1, in priority order:
  1. push & pop together: both ignored, PC = PC+1, stack_err set.
  2. pop & !empty: PC = top, occupancy-1.
  3. pop & empty: stack_err set, PC = PC+1.
  4. push & !full: pushes PC+1, then PC follows branch/increment.
  5. push & full: push dropped, stack_err set, PC follows branch/increment.
  6. branch: PC = mem_addr.
  7. Otherwise: PC = PC+1, wrapping modulo 2^ADDR_W.
- stack_push/stack_pop with pc_enable=0 are ignored.
- stack_err clears only on reset.
- Register file:
  - Writes bus_c to reg[c_addr] on clk when write_reg_enable=1.
  - Reads are combinational; bus_a = reg[a_addr], bus_b = reg[b_addr].
  - A write is visible to reads from the following cycle.
- ALU ops:
  - 000 OR, 001 ADD, 010 SUB (a + ~b + 1), 011 AND, 100 XOR.
  - 101 SHL1, 110 SHR1 (logical), 111 PASS_A.
- ALU flags (combinational; registered into the four outputs on clk when flags_reg_enable=1):
  - zero = result==0; neg = result[DATA_W-1].
  - ADD: unsigned_ovf = carry out; signed_ovf = carry into MSB XOR carry out.
  - SUB: unsigned_ovf = borrow (a<b unsigned); signed_ovf = operands of differing sign and result sign != a sign.
  - SHL1: unsigned_ovf = bus_a[DATA_W-1]; signed_ovf = 0.
  - All other ops: both ovf = 0.
- Decoder (combinational):
  - opcode = instruction[DATA_W-1 -: 8].
  - Default all fields to 0; unknown opcode = I_NOP.
  - LOAD 0x81: c = [ADDR_W+RW-1:ADDR_W], mem = [ADDR_W-1:0].
  - STORE 0x82: a = same register field, mem = [ADDR_W-1:0].
  - MOVE 0x91: c = [2RW-1:RW], a = b = [RW-1:0].
  - ALU group, a = [RW-1:0], b = [2RW-1:RW], c = [3RW-1:2RW]: ADD 0xA1, SUB 0xA2, AND 0xA3, OR 0xA4, XOR 0xA5, SHL 0xA6, SHR 0xA7.
  - Branch group, mem = [ADDR_W-1:0]: BRANCH 0x01, BZERO 0x02, BNEG 0x03, BOV 0x05, BNOV 0x06, BNNEG 0x0A, BNZERO 0x0B, CALL 0x0C.
  - RET 0x0D and HALT 0xFF carry no fields.
  - decoded_instruction_type is extended with I_XOR, I_SHL, I_SHR, I_CALL, I_RET.
- Muxes: ram_addr = addr_sel ? PC : mem_addr; bus_c = c_sel ? ALU result : data_in.

Test Plan:
- Reset mid-run with PC=7, reg1=0x1234, stack holding 2 entries -> next cycle all outputs 0, stack_empty=1, decoded_instruction = I_NOP.
- Registers r0=0x7FFF, r1=0x0001, ADD with flags_reg_enable -> result 0x8000; flags after clk: neg=1, signed_ovf=1, unsigned_ovf=0, zero=0.
- SUB with 0x0003 - 0x0005 -> result 0xFFFE; unsigned_ovf=1, signed_ovf=0, neg=1.
- CALL at PC=4 to address 0x10 (push+branch+pc_enable) -> PC=0x10, stack_empty=0; later RET (pop) -> PC=5.
- Five pushes with STACK_DEPTH=4 -> stack_full=1 after the 4th push, stack_err=1 after the 5th; then pops return entries in reverse order, the 4th pop leaves stack_empty=1, and an extra pop increments PC.
- PC=31 with ADDR_W=5, increment -> PC=0. Also: push and pop in the same cycle -> stack occupancy unchanged, stack_err=1.

Source files
------------

// File: rtl/ks_data_path_param.sv
// K&S data path: PC, IR, decoder, register file, 8-op ALU, flags and a
// return-address stack for CALL/RET. The control unit drives every enable and select.
package ks_pkg;
  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT,
    I_XOR, I_SHL, I_SHR, I_CALL, I_RET
  } decoded_instruction_type;
endpackage

module ks_data_path_param
  import ks_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [2:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic                    stack_push,
  input  logic                    stack_pop,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic                    stack_empty,
  output logic                    stack_full,
  output logic                    stack_err,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int M  = DATA_W - 1;

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, mem_addr;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [RW-1:0]     a_addr, b_addr, c_addr;
  logic [DATA_W-1:0] bus_a, bus_b, bus_c, alu_r;
  logic [DATA_W:0]   sum;
  logic              alu_uovf, alu_sovf;
  logic [7:0]        opcode;

  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     push_idx, top_idx;
  logic              err_q, err_d, push_we;

  // Decoder
  always_comb begin
    opcode = ir_q[DATA_W-1 -: 8];
    decoded_instruction = I_NOP;
    a_addr = '0;
    b_addr = '0;
    c_addr = '0;
    mem_addr = '0;
    case (opcode)
      8'h81: begin
        decoded_instruction = I_LOAD;
        c_addr = ir_q[ADDR_W+RW-1:ADDR_W];
        mem_addr = ir_q[ADDR_W-1:0];
      end
      8'h82: begin
        decoded_instruction = I_STORE;
        a_addr = ir_q[ADDR_W+RW-1:ADDR_W];
        mem_addr = ir_q[ADDR_W-1:0];
      end
      8'h91: begin
        decoded_instruction = I_MOVE;
        c_addr = ir_q[2*RW-1:RW];
        a_addr = ir_q[RW-1:0];
        b_addr = ir_q[RW-1:0];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7: begin
        a_addr = ir_q[RW-1:0];
        b_addr = ir_q[2*RW-1:RW];
        c_addr = ir_q[3*RW-1:2*RW];
        case (opcode[2:0])
          3'd1:    decoded_instruction = I_ADD;
          3'd2:    decoded_instruction = I_SUB;
          3'd3:    decoded_instruction = I_AND;
          3'd4:    decoded_instruction = I_OR;
          3'd5:    decoded_instruction = I_XOR;
          3'd6:    decoded_instruction = I_SHL;
          default: decoded_instruction = I_SHR;
        endcase
      end
      8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'h0C: begin
        mem_addr = ir_q[ADDR_W-1:0];
        case (opcode[3:0])
          4'h1:    decoded_instruction = I_BRANCH;
          4'h2:    decoded_instruction = I_BZERO;
          4'h3:    decoded_instruction = I_BNEG;
          4'h5:    decoded_instruction = I_BOV;
          4'h6:    decoded_instruction = I_BNOV;
          4'hA:    decoded_instruction = I_BNNEG;
          4'hB:    decoded_instruction = I_BNZERO;
          default: decoded_instruction = I_CALL;
        endcase
      end
      8'h0D: decoded_instruction = I_RET;
      8'hFF: decoded_instruction = I_HALT;
      default: ;
    endcase
  end

  assign bus_a    = regs_q[a_addr];
  assign bus_b    = regs_q[b_addr];
  assign bus_c    = c_sel ? alu_r : data_in;
  assign data_out = bus_a;
  assign ram_addr = addr_sel ? pc_q : mem_addr;

  // ALU; SUB is a + ~b + 1 so the sum's top bit is the inverted borrow
  always_comb begin
    alu_r = '0;
    sum = '0;
    alu_uovf = 1'b0;
    alu_sovf = 1'b0;
    case (operation)
      3'b000: alu_r = bus_a | bus_b;
      3'b001: begin
        sum = {1'b0, bus_a} + {1'b0, bus_b};
        alu_r = sum[M:0];
        alu_uovf = sum[DATA_W];
        alu_sovf = (bus_a[M] ^ bus_b[M] ^ alu_r[M]) ^ sum[DATA_W];
      end
      3'b010: begin
        sum = {1'b0, bus_a} + {1'b0, ~bus_b} + {{DATA_W{1'b0}}, 1'b1};
        alu_r = sum[M:0];
        alu_uovf = bus_a < bus_b;
        alu_sovf = (bus_a[M] != bus_b[M]) && (alu_r[M] != bus_a[M]);
      end
      3'b011: alu_r = bus_a & bus_b;
      3'b100: alu_r = bus_a ^ bus_b;
      3'b101: begin
        alu_r = {bus_a[M-1:0], 1'b0};
        alu_uovf = bus_a[M];
      end
      3'b110: alu_r = {1'b0, bus_a[M:1]};
      default: alu_r = bus_a;
    endcase
  end

  assign stack_empty = (cnt_q == '0);
  assign stack_full  = (cnt_q == CW'(STACK_DEPTH));
  assign stack_err   = err_q;
  assign push_idx    = cnt_q[IW-1:0];
  assign top_idx     = push_idx - IW'(1);
  assign pc_inc      = pc_q + ADDR_W'(1);

  // PC / stack next state, priority: push+pop, pop, push, branch, increment
  always_comb begin
    pc_d = pc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push_we = 1'b0;
    if (pc_enable) begin
      if (stack_push && stack_pop) begin
        pc_d = pc_inc;
        err_d = 1'b1;
      end else if (stack_pop) begin
        if (!stack_empty) begin
          pc_d = stk_q[top_idx];
          cnt_d = cnt_q - CW'(1);
        end else begin
          pc_d = pc_inc;
          err_d = 1'b1;
        end
      end else begin
        if (stack_push) begin
          if (!stack_full) begin
            push_we = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        pc_d = branch ? mem_addr : pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ir_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      zero_op <= 1'b0;
      neg_op <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (ir_enable) ir_q <= data_in;
      if (write_reg_enable) regs_q[c_addr] <= bus_c;
      if (push_we) stk_q[push_idx] <= pc_inc;
      if (flags_reg_enable) begin
        zero_op <= (alu_r == '0);
        neg_op <= alu_r[M];
        unsigned_overflow <= alu_uovf;
        signed_overflow <= alu_sovf;
      end
    end
  end
endmodule
